neopix_rx: RTL and testbench
============================

Name: neopix_rx

Overview:
- WS2812 one-wire line decoder: the receiving end of the DO stream produced by spi_to_neopix.
- Samples an asynchronous DI pin, measures each high pulse to decode bits, and assembles 24-bit GRB pixels MSB-first.
- Presents each pixel with its index and signals frame end on the latch (reset) gap.
- Serves as a loopback checker for the neopixel transmitters and as a front end for chaining boards.

Parameters:
- NUM_LEDS, 256: maximum pixels accepted per frame; further pixels are dropped.
- T1_THRESH_CLKS, 30: high-time threshold; high >= 30 clks (600 ns at 50 MHz) decodes as 1, else 0.
- MIN_HIGH_CLKS, 5: high pulses shorter than this are glitches.
- MAX_HIGH_CLKS, 100: high time reaching this is a stuck/long-high error.
- RESET_CLKS, 2500: consecutive low clocks that form a latch gap (50 us).

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-high reset.
- DI  in  1  asynchronous WS2812 data input.
- PIX_DATA  out  24  last decoded pixel, GRB, first-received bit at [23].
- PIX_INDEX  out  $clog2(NUM_LEDS)  index of PIX_DATA within the frame.
- PIX_VALID  out  1  one-cycle strobe; PIX_DATA/PIX_INDEX valid this cycle.
- FRAME_DONE  out  1  one-cycle strobe at latch gap after at least one bit.
- PIX_COUNT  out  $clog2(NUM_LEDS+1)  pixels accepted in the frame; updated with FRAME_DONE.
- ERR  out  1  one-cycle error strobe.
- ERR_CODE  out  2  0 overflow, 1 glitch, 2 long high, 3 partial pixel; held until the next ERR.

Behaviour:
- Reset values: all outputs 0. State S_SYNC; all counters and shift register 0.
- DI passes through a 2-flop synchronizer to give di_s. Edges are detected against the registered di_s.
- All "cycle" references below are counted on di_s.
- States and transitions:
  - S_SYNC: lcnt increments while di_s is low and clears to 0 when di_s is high. When lcnt reaches RESET_CLKS, go to S_IDLE. No strobes are issued.
  - S_IDLE: bit_cnt=0, pix_idx=0. A rising edge goes to S_HIGH with hcnt=1.
  - S_HIGH: hcnt increments per high cycle.
    - If hcnt reaches MAX_HIGH_CLKS: ERR, code 2, go to S_SYNC (lcnt=0).
    - On a falling edge with hcnt < MIN_HIGH_CLKS: ERR, code 1, go to S_SYNC.
    - Otherwise shift in bit (hcnt >= T1_THRESH_CLKS), bit_cnt++, go to S_LOW with lcnt=1.
  - S_LOW: lcnt increments.
    - A rising edge goes to S_HIGH with hcnt=1.
    - When lcnt reaches RESET_CLKS: FRAME_DONE=1, PIX_COUNT=min(pixels, NUM_LEDS), go to S_IDLE.
    - If bit_cnt != 0 at that point, also ERR, code 3, in the same cycle; the partial pixel is discarded.
- Pixel completion:
  - When bit_cnt reaches 24 on a falling edge and pix_idx < NUM_LEDS: on the next CLK edge PIX_DATA=shift, PIX_INDEX=pix_idx, PIX_VALID=1 for one cycle. Then pix_idx++ and bit_cnt=0.
  - If pix_idx == NUM_LEDS: no PIX_VALID; ERR, code 0, once per dropped pixel; pix_idx saturates.
- Latency: PIX_VALID asserts 4 CLK edges after the DI falling edge of bit 24 (2 synchronizer + 1 edge detect + 1 output register).
- PIX_DATA and PIX_INDEX hold their values between strobes.
- Simultaneous events: ERR code 3 and FRAME_DONE may share a cycle. PIX_VALID and FRAME_DONE can never coincide, because the gap requires RESET_CLKS of low first.
- Asserting RESET mid-frame returns to S_SYNC immediately. The first frame after reset is decoded only after a full latch gap, so a frame in progress at reset is never partially accepted.

Decomposition:
- Package neopix_pkg holds:
  - the timing constants shared with spi_to_neopix (T0H=20, T1H=40, period=62, RESET_CLKS);
  - the rx state enum;
  - the ERR_CODE localparams.
- Sub-module neopix_pulse_meter: synchronizer, edge detect, and saturating hcnt/lcnt counters. It outputs a bit strobe with value, a glitch flag, a long-high flag and a gap flag. The FSM and pixel assembly stay in neopix_rx.

Test Plan:
- 2600 low cycles, then pixel 0x123456 (T0H=20/T1H=40, period 62 clks), then 2600 low -> one PIX_VALID with PIX_DATA=0x123456, PIX_INDEX=0; FRAME_DONE with PIX_COUNT=1; no ERR.
- Frame of 3 pixels 0xFF0000, 0x00FF00, 0x0000FF -> PIX_INDEX 0,1,2 in order, PIX_COUNT=3.
- Threshold edges: high of 29 clks decodes 0, 30 clks decodes 1; high of 4 clks -> ERR code 1. Subsequent bits are ignored until 2500 low, then the next frame decodes correctly.
- DI held high 100 clks -> ERR code 2, no FRAME_DONE. After 2500 low, a clean pixel decodes.
- 12 bits then a gap -> FRAME_DONE with ERR code 3 in the same cycle, PIX_COUNT=0, no PIX_VALID.
- NUM_LEDS=4, 6 pixels sent -> 4 PIX_VALIDs, 2 ERR code 0, PIX_COUNT=4. RESET pulsed mid-pixel -> all outputs 0, no strobe until after the next gap.

Source files
------------

// File: rtl/neopix_pkg.sv
// neopix_pkg: definitions shared by the WS2812 receive path.
//   - Line timing constants. They match spi_to_neopix, so the transmitter and
//     this receiver agree on T0H, T1H, bit period and latch gap.
//   - The receive FSM state encoding.
//   - The ERR_CODE values reported by neopix_rx.
package neopix_pkg;

   // Line timing in 50 MHz clocks.
   localparam int NP_T0H_CLKS    = 20;
   localparam int NP_T1H_CLKS    = 40;
   localparam int NP_PERIOD_CLKS = 62;
   localparam int NP_RESET_CLKS  = 2500;

   typedef enum logic [1:0] {
      S_SYNC,   // waiting for a full latch gap before trusting the line
      S_IDLE,   // between frames, waiting for the first rising edge
      S_HIGH,   // measuring a high pulse
      S_LOW     // low between bits, or a latch gap in progress
   } rx_state_t;

   localparam logic [1:0] ERR_OVERFLOW  = 2'd0;
   localparam logic [1:0] ERR_GLITCH    = 2'd1;
   localparam logic [1:0] ERR_LONG_HIGH = 2'd2;
   localparam logic [1:0] ERR_PARTIAL   = 2'd3;

endpackage

// File: rtl/neopix_pulse_meter.sv
// neopix_pulse_meter: front end of the WS2812 receiver.
// It synchronises DI, detects edges, and measures high and low run lengths
// with saturating counters. Every event comes out registered, one cycle after
// the synchronised edge that caused it, so all events share one pipeline
// delay and reach the FSM in line order.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   di         in   asynchronous line input
//   bit_stb    out  a valid high pulse ended; its bit value is on bit_val
//   bit_val    out  decoded bit (high time >= T1_THRESH_CLKS)
//   glitch     out  a high pulse ended shorter than MIN_HIGH_CLKS
//   long_high  out  high time just reached MAX_HIGH_CLKS
//   gap        out  low time just reached RESET_CLKS
//   rise       out  rising edge of the synchronised line
module neopix_pulse_meter
   import neopix_pkg::*;
#(
   parameter int T1_THRESH_CLKS = 30,
   parameter int MIN_HIGH_CLKS  = 5,
   parameter int MAX_HIGH_CLKS  = 100,
   parameter int RESET_CLKS     = NP_RESET_CLKS
) (
   input  logic clk,
   input  logic rst,
   input  logic di,
   output logic bit_stb,
   output logic bit_val,
   output logic glitch,
   output logic long_high,
   output logic gap,
   output logic rise
);

   localparam int HW = $clog2(MAX_HIGH_CLKS + 1);
   localparam int LW = $clog2(RESET_CLKS + 1);
   localparam logic [HW-1:0] H_MAX  = HW'(MAX_HIGH_CLKS);
   localparam logic [HW-1:0] H_LAST = HW'(MAX_HIGH_CLKS - 1);
   localparam logic [HW-1:0] H_MIN  = HW'(MIN_HIGH_CLKS);
   localparam logic [HW-1:0] H_T1   = HW'(T1_THRESH_CLKS);
   localparam logic [LW-1:0] L_MAX  = LW'(RESET_CLKS);
   localparam logic [LW-1:0] L_LAST = LW'(RESET_CLKS - 1);

   logic          di_meta_q, di_meta_d;
   logic          di_s_q, di_s_d;
   logic          di_prev_q, di_prev_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          bit_stb_q, bit_stb_d;
   logic          bit_val_q, bit_val_d;
   logic          glitch_q, glitch_d;
   logic          long_high_q, long_high_d;
   logic          gap_q, gap_d;
   logic          rise_q, rise_d;
   logic          fall_w;

   always_comb begin
      di_meta_d = di;
      di_s_d    = di_meta_q;
      di_prev_d = di_s_q;
      fall_w    = ~di_s_q & di_prev_q;
      rise_d    = di_s_q & ~di_prev_q;

      // hcnt_q holds the length of the high run so far. On the fall cycle it
      // holds the full pulse width in clocks.
      hcnt_d = '0;
      if (di_s_q) begin
         hcnt_d = (hcnt_q == H_MAX) ? H_MAX : hcnt_q + 1'b1;
      end
      lcnt_d = '0;
      if (!di_s_q) begin
         lcnt_d = (lcnt_q == L_MAX) ? L_MAX : lcnt_q + 1'b1;
      end

      // A pulse that already saturated has been reported as long_high, so its
      // falling edge produces no further event.
      bit_stb_d   = fall_w && (hcnt_q >= H_MIN) && (hcnt_q < H_MAX);
      bit_val_d   = (hcnt_q >= H_T1);
      glitch_d    = fall_w && (hcnt_q < H_MIN);
      long_high_d = di_s_q && (hcnt_q == H_LAST);
      gap_d       = !di_s_q && (lcnt_q == L_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         di_meta_q   <= 1'b0;
         di_s_q      <= 1'b0;
         di_prev_q   <= 1'b0;
         hcnt_q      <= '0;
         lcnt_q      <= '0;
         bit_stb_q   <= 1'b0;
         bit_val_q   <= 1'b0;
         glitch_q    <= 1'b0;
         long_high_q <= 1'b0;
         gap_q       <= 1'b0;
         rise_q      <= 1'b0;
      end else begin
         di_meta_q   <= di_meta_d;
         di_s_q      <= di_s_d;
         di_prev_q   <= di_prev_d;
         hcnt_q      <= hcnt_d;
         lcnt_q      <= lcnt_d;
         bit_stb_q   <= bit_stb_d;
         bit_val_q   <= bit_val_d;
         glitch_q    <= glitch_d;
         long_high_q <= long_high_d;
         gap_q       <= gap_d;
         rise_q      <= rise_d;
      end
   end

   assign bit_stb   = bit_stb_q;
   assign bit_val   = bit_val_q;
   assign glitch    = glitch_q;
   assign long_high = long_high_q;
   assign gap       = gap_q;
   assign rise      = rise_q;

endmodule

// File: rtl/neopix_rx.sv
// neopix_rx: WS2812 line decoder. It assembles 24-bit GRB pixels MSB-first,
// strobes each pixel with its index, and reports frame end on the latch gap.
// Ports:
//   CLK         in   system clock (50 MHz)
//   RESET       in   asynchronous active-high reset
//   DI          in   asynchronous WS2812 data input
//   PIX_DATA    out  last decoded pixel, first-received bit at [23]
//   PIX_INDEX   out  index of PIX_DATA within the frame
//   PIX_VALID   out  one-cycle pixel strobe
//   FRAME_DONE  out  one-cycle strobe at a latch gap that follows at least one bit
//   PIX_COUNT   out  pixels accepted in the frame, updated with FRAME_DONE
//   ERR         out  one-cycle error strobe
//   ERR_CODE    out  cause of the last ERR, held until the next ERR
module neopix_rx
   import neopix_pkg::*;
#(
   parameter int NUM_LEDS       = 256,
   parameter int T1_THRESH_CLKS = 30,
   parameter int MIN_HIGH_CLKS  = 5,
   parameter int MAX_HIGH_CLKS  = 100,
   parameter int RESET_CLKS     = NP_RESET_CLKS
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          DI,
   output logic [23:0]                   PIX_DATA,
   output logic [$clog2(NUM_LEDS)-1:0]   PIX_INDEX,
   output logic                          PIX_VALID,
   output logic                          FRAME_DONE,
   output logic [$clog2(NUM_LEDS+1)-1:0] PIX_COUNT,
   output logic                          ERR,
   output logic [1:0]                    ERR_CODE
);

   localparam int IW = $clog2(NUM_LEDS);
   localparam int CW = $clog2(NUM_LEDS + 1);

   logic bit_stb, bit_val, glitch, long_high, gap, rise;

   neopix_pulse_meter #(
      .T1_THRESH_CLKS (T1_THRESH_CLKS),
      .MIN_HIGH_CLKS  (MIN_HIGH_CLKS),
      .MAX_HIGH_CLKS  (MAX_HIGH_CLKS),
      .RESET_CLKS     (RESET_CLKS)
   ) u_meter (
      .clk       (CLK),
      .rst       (RESET),
      .di        (DI),
      .bit_stb   (bit_stb),
      .bit_val   (bit_val),
      .glitch    (glitch),
      .long_high (long_high),
      .gap       (gap),
      .rise      (rise)
   );

   rx_state_t     state_q, state_d;
   logic [23:0]   shift_q, shift_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [CW-1:0] pix_idx_q, pix_idx_d;     // saturates at NUM_LEDS
   logic [23:0]   pix_data_q, pix_data_d;
   logic [IW-1:0] pix_index_q, pix_index_d;
   logic          pix_valid_q, pix_valid_d;
   logic          frame_done_q, frame_done_d;
   logic [CW-1:0] pix_count_q, pix_count_d;
   logic          err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [23:0]   shift_w;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      pix_idx_d    = pix_idx_q;
      pix_data_d   = pix_data_q;
      pix_index_d  = pix_index_q;
      pix_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      pix_count_d  = pix_count_q;
      err_d        = 1'b0;
      err_code_d   = err_code_q;
      shift_w      = {shift_q[22:0], bit_val};

      case (state_q)
         S_SYNC: begin
            if (gap) state_d = S_IDLE;
         end
         S_IDLE: begin
            bit_cnt_d = '0;
            pix_idx_d = '0;
            shift_d   = '0;
            if (rise) state_d = S_HIGH;
         end
         S_HIGH: begin
            if (long_high) begin
               err_d      = 1'b1;
               err_code_d = ERR_LONG_HIGH;
               state_d    = S_SYNC;
            end else if (glitch) begin
               err_d      = 1'b1;
               err_code_d = ERR_GLITCH;
               state_d    = S_SYNC;
            end else if (bit_stb) begin
               state_d = S_LOW;
               shift_d = shift_w;
               if (bit_cnt_q == 5'd23) begin
                  // The 24th bit is shifted in and published on the same edge.
                  bit_cnt_d = '0;
                  if (pix_idx_q < CW'(NUM_LEDS)) begin
                     pix_data_d  = shift_w;
                     pix_index_d = pix_idx_q[IW-1:0];
                     pix_valid_d = 1'b1;
                     pix_idx_d   = pix_idx_q + 1'b1;
                  end else begin
                     err_d      = 1'b1;
                     err_code_d = ERR_OVERFLOW;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_LOW: begin
            if (rise) begin
               state_d = S_HIGH;
            end else if (gap) begin
               frame_done_d = 1'b1;
               pix_count_d  = pix_idx_q;
               state_d      = S_IDLE;
               if (bit_cnt_q != 5'd0) begin
                  err_d      = 1'b1;
                  err_code_d = ERR_PARTIAL;
               end
            end
         end
         default: state_d = S_SYNC;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         pix_idx_q    <= '0;
         pix_data_q   <= '0;
         pix_index_q  <= '0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         pix_count_q  <= '0;
         err_q        <= 1'b0;
         err_code_q   <= '0;
      end else begin
         shift_q      <= shift_d;
         bit_cnt_q    <= bit_cnt_d;
         pix_idx_q    <= pix_idx_d;
         pix_data_q   <= pix_data_d;
         pix_index_q  <= pix_index_d;
         pix_valid_q  <= pix_valid_d;
         frame_done_q <= frame_done_d;
         pix_count_q  <= pix_count_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign PIX_DATA   = pix_data_q;
   assign PIX_INDEX  = pix_index_q;
   assign PIX_VALID  = pix_valid_q;
   assign FRAME_DONE = frame_done_q;
   assign PIX_COUNT  = pix_count_q;
   assign ERR        = err_q;
   assign ERR_CODE   = err_code_q;

endmodule

// File: tb/tb_neopix_rx.sv
// tb_neopix_rx: drives the line as a list of (high, low) pulse widths. A
// pulse-level model of the protocol predicts the ordered pixel, frame and
// error events; a monitor records what the DUT strobes, and each phase
// compares the two lists.
module tb_neopix_rx;

   localparam int NUM_LEDS  = 4;
   localparam int T1_THRESH = 30;
   localparam int MIN_HIGH  = 5;
   localparam int MAX_HIGH  = 100;
   localparam int RESET_GAP = 2500;
   localparam int GAP_SEND  = 2600;
   localparam int T0H       = 20;
   localparam int T1H       = 40;
   localparam int BIT_CLKS  = 62;

   localparam int EV_PIX   = 0;
   localparam int EV_FRAME = 1;
   localparam int EV_ERR   = 2;

   logic        clk;
   logic        rst;
   logic        di;
   logic [23:0] pix_data;
   logic [1:0]  pix_index;
   logic        pix_valid;
   logic        frame_done;
   logic [2:0]  pix_count;
   logic        err;
   logic [1:0]  err_code;

   neopix_rx #(.NUM_LEDS(NUM_LEDS)) dut (
      .CLK        (clk),
      .RESET      (rst),
      .DI         (di),
      .PIX_DATA   (pix_data),
      .PIX_INDEX  (pix_index),
      .PIX_VALID  (pix_valid),
      .FRAME_DONE (frame_done),
      .PIX_COUNT  (pix_count),
      .ERR        (err),
      .ERR_CODE   (err_code)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          kind;
      logic [23:0] data;
      int          aux;    // pixel index, pixel count or error code
      bit          same;   // FRAME_DONE only: ERR in the same cycle
   } ev_t;

   ev_t obs_q[$];
   ev_t exp_q[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  last_pix_cyc  = 0;
   int  last_fall_cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: record every strobe in the order the line produced it.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (pix_valid) begin
               e.kind = EV_PIX; e.data = pix_data; e.aux = int'(pix_index); e.same = 1'b0;
               obs_q.push_back(e);
               last_pix_cyc = cyc;
            end
            if (frame_done) begin
               e.kind = EV_FRAME; e.data = '0; e.aux = int'(pix_count); e.same = err;
               obs_q.push_back(e);
            end
            if (err) begin
               e.kind = EV_ERR; e.data = '0; e.aux = int'(err_code); e.same = 1'b0;
               obs_q.push_back(e);
            end
         end
      end
   end

   // ---------------- reference model (pulse level) ----------------
   bit          m_synced;
   bit          m_active;
   int          m_bits;
   int          m_pix;
   int          m_low_run;
   logic [23:0] m_shift;

   task automatic push_exp(input int kind, input logic [23:0] data, input int aux, input bit same);
      ev_t e;
      e.kind = kind; e.data = data; e.aux = aux; e.same = same;
      exp_q.push_back(e);
   endtask

   task automatic m_reset();
      m_synced = 0; m_active = 0; m_bits = 0; m_pix = 0; m_low_run = 0; m_shift = '0;
   endtask

   task automatic m_high(input int h);
      m_low_run = 0;
      if (!m_synced) return;
      if (h >= MAX_HIGH) begin
         push_exp(EV_ERR, '0, 2, 0);
         m_synced = 0;
         return;
      end
      if (h < MIN_HIGH) begin
         push_exp(EV_ERR, '0, 1, 0);
         m_synced = 0;
         return;
      end
      m_active = 1;
      m_shift  = {m_shift[22:0], (h >= T1_THRESH)};
      m_bits++;
      if (m_bits == 24) begin
         m_bits = 0;
         if (m_pix < NUM_LEDS) begin
            push_exp(EV_PIX, m_shift, m_pix, 0);
            m_pix++;
         end else begin
            push_exp(EV_ERR, '0, 0, 0);
         end
      end
   endtask

   task automatic m_low(input int l);
      int prev;
      prev = m_low_run;
      m_low_run += l;
      if (prev < RESET_GAP && m_low_run >= RESET_GAP) begin
         if (m_synced && m_active) begin
            push_exp(EV_FRAME, '0, m_pix, (m_bits != 0));
            if (m_bits != 0) push_exp(EV_ERR, '0, 3, 0);
         end
         m_synced = 1; m_active = 0; m_bits = 0; m_pix = 0; m_shift = '0;
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic drive(input logic lvl, input int n);
      di = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      drive(1'b1, h);
      m_high(h);
      last_fall_cyc = cyc;
      drive(1'b0, l);
      m_low(l);
   endtask

   task automatic lo(input int l);
      drive(1'b0, l);
      m_low(l);
   endtask

   task automatic send_bits(input logic [23:0] px, input int nbits, input int h1, input int h0);
      for (int i = 23; i > 23 - nbits; i--) begin
         if (px[i]) pulse(h1, BIT_CLKS - h1);
         else       pulse(h0, BIT_CLKS - h0);
      end
   endtask

   task automatic send_pixel(input logic [23:0] px);
      send_bits(px, 24, T1H, T0H);
   endtask

   task automatic compare_events(input string tag);
      int n;
      check_val({tag, " event count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         $display("[TB] %s ev%0d kind=%0d data=%06h aux=%0d same=%0d / exp kind=%0d data=%06h aux=%0d same=%0d",
                  tag, i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, obs_q[i].same,
                  exp_q[i].kind, exp_q[i].data, exp_q[i].aux, exp_q[i].same);
         check_val($sformatf("%s ev%0d kind", tag, i), obs_q[i].kind, exp_q[i].kind);
         check_val($sformatf("%s ev%0d data", tag, i), obs_q[i].data, exp_q[i].data);
         check_val($sformatf("%s ev%0d aux", tag, i), obs_q[i].aux, exp_q[i].aux);
         check_val($sformatf("%s ev%0d same", tag, i), obs_q[i].same, exp_q[i].same);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, " PIX_DATA"}, pix_data, 0);
      check_val({tag, " PIX_INDEX"}, pix_index, 0);
      check_val({tag, " PIX_VALID"}, pix_valid, 0);
      check_val({tag, " FRAME_DONE"}, frame_done, 0);
      check_val({tag, " PIX_COUNT"}, pix_count, 0);
      check_val({tag, " ERR"}, err, 0);
      check_val({tag, " ERR_CODE"}, err_code, 0);
   endtask

   initial begin
      #(20 * 98000);
      $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1);
   end

   initial begin
      logic [23:0] px;
      int          np, h, l;

      rst = 1'b1;
      di  = 1'b0;
      m_reset();
      repeat (5) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      m_reset();

      // Initial gap only synchronises: no strobes.
      lo(GAP_SEND);
      compare_events("sync");

      // Single pixel, with PIX_VALID latency from the last falling edge.
      send_pixel(24'h123456);
      lo(GAP_SEND);
      check_val("t1 latency", last_pix_cyc - last_fall_cyc, 4);
      check_val("t1 PIX_DATA", pix_data, 24'h123456);
      check_val("t1 PIX_COUNT", pix_count, 1);
      compare_events("t1");

      // Three pixels, indices in order.
      send_pixel(24'hFF0000);
      send_pixel(24'h00FF00);
      send_pixel(24'h0000FF);
      lo(GAP_SEND);
      check_val("t2 PIX_INDEX", pix_index, 2);
      check_val("t2 PIX_COUNT", pix_count, 3);
      compare_events("t2");

      // Threshold: 30 clks high is a 1, 29 clks high is a 0.
      send_bits(24'hA5A5A5, 24, T1_THRESH, T1_THRESH - 1);
      lo(GAP_SEND);
      check_val("t3 thresh data", pix_data, 24'hA5A5A5);
      compare_events("t3 thresh");

      // Glitch of 4 clks mid-frame; later bits are ignored until a gap.
      send_bits(24'hF00000, 5, T1H, T0H);
      pulse(MIN_HIGH - 1, BIT_CLKS - MIN_HIGH + 1);
      send_bits(24'hFFFFFF, 24, T1H, T0H);
      lo(GAP_SEND);
      send_pixel(24'h5A3C96);
      lo(GAP_SEND);
      check_val("t3 glitch ERR_CODE hold", err_code, 1);
      check_val("t3 recover data", pix_data, 24'h5A3C96);
      compare_events("t3 glitch");

      // Overflow: 6 pixels into a 4-pixel receiver.
      for (int p = 0; p < 6; p++) send_pixel(24'h010203 * (p + 1));
      lo(GAP_SEND);
      check_val("t6 PIX_COUNT", pix_count, 4);
      check_val("t6 ERR_CODE hold", err_code, 0);
      compare_events("t6 overflow");

      // Partial pixel: 12 bits, then a gap.
      send_bits(24'hABC000, 12, T1H, T0H);
      lo(GAP_SEND);
      check_val("t5 PIX_COUNT", pix_count, 0);
      check_val("t5 ERR_CODE hold", err_code, 3);
      compare_events("t5 partial");

      // Stuck high for 100 clks, then recovery.
      pulse(MAX_HIGH, GAP_SEND);
      check_val("t4 ERR_CODE hold", err_code, 2);
      send_pixel(24'h0F1E2D);
      lo(GAP_SEND);
      check_val("t4 recover data", pix_data, 24'h0F1E2D);
      compare_events("t4 long");

      // Reset in the middle of a pixel.
      send_pixel(24'hC0FFEE);
      send_bits(24'h123456, 10, T1H, T0H);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("mid reset");
      rst = 1'b0;
      m_reset();
      send_bits(24'h123456, 14, T1H, T0H);
      send_pixel(24'h777777);
      lo(GAP_SEND);
      send_pixel(24'h3355AA);
      lo(GAP_SEND);
      check_val("reset recover data", pix_data, 24'h3355AA);
      compare_events("reset");

      // Random frames with random pulse widths inside the valid ranges.
      for (int f = 0; f < 3; f++) begin
         np = int'($urandom_range(1, 3));
         for (int p = 0; p < np; p++) begin
            px = 24'($urandom);
            for (int i = 23; i >= 0; i--) begin
               if (px[i]) h = int'($urandom_range(T1_THRESH, MAX_HIGH - 1));
               else       h = int'($urandom_range(MIN_HIGH, T1_THRESH - 1));
               l = int'($urandom_range(6, 40));
               pulse(h, l);
            end
         end
         lo(GAP_SEND);
         compare_events($sformatf("rand%0d", f));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
